rptr_empty_lvl: RTL and testbench
=================================

// Module: rptr_empty_lvl
// PURPOSE
// Read-side pointer/flag block for the async FIFO, successor to the basic read-pointer/empty logic.
// Sits in the read clock domain: owns the gray/binary read pointer and the memory read address.
// Synchronises the write-domain gray pointer internally with SYNC_STAGES flops.
// Adds a fill level output, a programmable almost-empty flag and a sticky underflow error flag.
// PARAMETERS
// ADDRSIZE     4  FIFO depth = 2**ADDRSIZE; pointers are ADDRSIZE+1 bits wide
// SYNC_STAGES  2  wptr synchroniser depth, legal range 2..4
// PORTS
// rclk        in   1           read-domain clock; all flops on rising edge
// rrst_n      in   1           synchronous active-low reset, sampled on rclk
// rinc        in   1           pop request (ignored while rempty=1)
// wptr        in   ADDRSIZE+1  write pointer, gray coded, asynchronous to rclk
// ae_thresh   in   ADDRSIZE+1  almost-empty threshold (quasi-static)
// uf_clr      in   1           clears runderflow
// raddr       out  ADDRSIZE    memory read address = rbin[ADDRSIZE-1:0]
// rptr        out  ADDRSIZE+1  registered gray read pointer, to the write domain
// rempty      out  1           FIFO empty
// raempty     out  1           level <= ae_thresh
// rlevel      out  ADDRSIZE+1  entries available, 0..2**ADDRSIZE
// runderflow  out  1           sticky: pop attempted while empty
// BEHAVIOUR
// - Reset (rrst_n=0 at rclk edge): rbin=0, rptr=0, sync flops=0, rempty=1, raempty=1, rlevel=0, runderflow=0.
//   This holds for a reset mid-operation; an in-flight pop is discarded.
// - pop = rinc & ~rempty; rbinnext = rbin + pop (mod 2**(ADDRSIZE+1)); rgraynext = (rbinnext>>1)^rbinnext.
// - Registers: rbin<=rbinnext, rptr<=rgraynext every cycle. raddr is combinational from rbin.
// - Synchroniser: wq[0]<=wptr, wq[i]<=wq[i-1]; wq_gray = wq[SYNC_STAGES-1].
//   wq_bin = gray-to-binary of wq_gray (combinational).
// - rempty <= (rgraynext == wq_gray).
// - lvl_next = wq_bin - rbinnext, ADDRSIZE+1 bits, modular. Wrap of both pointers is handled by the modulo arithmetic.
//   rlevel <= lvl_next. lvl_next == 2**ADDRSIZE (full) is legal and is reported as such.
// - raempty <= (lvl_next <= ae_thresh). ae_thresh=0 makes raempty equal rempty.
// - runderflow <= (rinc & rempty) ? 1 : (uf_clr ? 0 : runderflow). Set wins over a simultaneous clear.
// - Latency: a wptr change reaches the flags and rlevel SYNC_STAGES+1 rclk edges after it is sampled.
//   A pop updates rempty, raempty and rlevel on the same edge that advances rptr.
// - Flags are pessimistic: rempty and raempty may assert late-to-deassert (sync lag), never early.
// - A pop on the edge where rempty falls is blocked; rempty is still 1 during that cycle.
// - wptr must change by at most one gray step per write-clock cycle; this is the writer's contract.
// TESTING (ADDRSIZE=4, SYNC_STAGES=2)
// 1. Reset, idle -> rempty=1, raempty=1, rlevel=0, rptr=0, raddr=0, runderflow=0.
// 2. ae_thresh=2; wptr=gray(5)=5'b00111 -> 3 edges later rempty=0, rlevel=5, raempty=0.
//    Then 3 pops -> rlevel=2, raempty=1. 2 more pops -> rempty=1, rlevel=0, raddr=5.
// 3. Wrap: preload rbin=14 by pops; wptr=gray(19) -> rlevel=5. 5 pops -> raddr 14,15,0,1,2,3; rptr=gray(19); rempty=1.
// 4. Full: rbin=0, wptr=gray(16)=5'b11000 -> rlevel=16, rempty=0, raempty=0 (ae_thresh=2).
// 5. rinc=1 while rempty=1 -> rbin unchanged, runderflow=1 next edge. It stays 1 until uf_clr.
//    uf_clr & rinc & rempty in the same cycle -> runderflow stays 1.
// 6. rrst_n=0 for one edge with rlevel=7 and rinc=1 -> all outputs at reset values next cycle.
//    After release, flags recover to rlevel=7 within SYNC_STAGES+1 edges if wptr is held.

Source files
------------

// File: rtl/rptr_empty_lvl.sv
// Read-domain pointer and flag block for the async FIFO: gray/binary read pointer,
// write-pointer synchroniser, fill level, almost-empty and sticky underflow flags.
module rptr_empty_lvl #(
  parameter int ADDRSIZE    = 4,
  parameter int SYNC_STAGES = 2   // legal 2..4
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic                rinc,
  input  logic [ADDRSIZE:0]   wptr,
  input  logic [ADDRSIZE:0]   ae_thresh,
  input  logic                uf_clr,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty,
  output logic                raempty,
  output logic [ADDRSIZE:0]   rlevel,
  output logic                runderflow
);

  localparam int PW = ADDRSIZE + 1;

  logic [PW-1:0]                  rbin, rbinnext, rgraynext;
  logic [PW-1:0]                  wq_gray, wq_bin, lvl_next;
  logic [SYNC_STAGES-1:0][PW-1:0] wq;
  logic                           pop;

  assign pop       = rinc & ~rempty;
  assign rbinnext  = rbin + {{(PW-1){1'b0}}, pop};
  assign rgraynext = (rbinnext >> 1) ^ rbinnext;
  assign raddr     = rbin[ADDRSIZE-1:0];
  assign wq_gray   = wq[SYNC_STAGES-1];

  // Each binary bit is the parity of all gray bits at or above it.
  genvar i;
  generate
    for (i = 0; i < PW; i++) begin : g_g2b
      assign wq_bin[i] = ^wq_gray[PW-1:i];
    end
  endgenerate

  // Modular difference covers pointer wrap; a value of 2**ADDRSIZE means full.
  assign lvl_next = wq_bin - rbinnext;

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      rbin       <= '0;
      rptr       <= '0;
      wq         <= '0;
      rempty     <= 1'b1;
      raempty    <= 1'b1;
      rlevel     <= '0;
      runderflow <= 1'b0;
    end else begin
      rbin       <= rbinnext;
      rptr       <= rgraynext;
      wq         <= {wq[SYNC_STAGES-2:0], wptr};
      rempty     <= (rgraynext == wq_gray);
      raempty    <= (lvl_next <= ae_thresh);
      rlevel     <= lvl_next;
      // A set in the same cycle as a clear keeps the flag raised.
      runderflow <= (rinc & rempty) | (runderflow & ~uf_clr);
    end
  end

endmodule

// File: tb/tb_rptr_empty_lvl.sv
// Bench for rptr_empty_lvl: directed scenarios plus randomized traffic, checked
// against a count-based model of the read side with a delay line for the sync lag.
module tb_rptr_empty_lvl;
  localparam int AW = 4;
  localparam int SS = 2;
  localparam int PW = AW + 1;
  localparam int MOD = 1 << PW;

  logic          rclk = 1'b0;
  logic          rrst_n, rinc, uf_clr;
  logic [PW-1:0] wptr, ae_thresh;
  logic [AW-1:0] raddr;
  logic [PW-1:0] rptr, rlevel;
  logic          rempty, raempty, runderflow;

  int checks = 0;
  int errors = 0;

  // model state
  int m_rcnt, m_lvl;
  bit m_empty, m_ae, m_uf;
  int hist[$];
  int w;

  rptr_empty_lvl #(.ADDRSIZE(AW), .SYNC_STAGES(SS)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .rinc(rinc), .wptr(wptr), .ae_thresh(ae_thresh),
    .uf_clr(uf_clr), .raddr(raddr), .rptr(rptr), .rempty(rempty), .raempty(raempty),
    .rlevel(rlevel), .runderflow(runderflow)
  );

  always #5 rclk = ~rclk;

  function automatic int gray(input int b);
    return (b ^ (b >> 1)) % MOD;
  endfunction

  function automatic int ungray(input int g);
    int b = 0;
    for (int k = PW - 1; k >= 0; k--) b = b | ((((b >> (k + 1)) & 1) ^ ((g >> k) & 1)) << k);
    return b;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("rempty",     int'(rempty),     int'(m_empty));
    chk("raempty",    int'(raempty),    int'(m_ae));
    chk("rlevel",     int'(rlevel),     m_lvl);
    chk("runderflow", int'(runderflow), int'(m_uf));
    chk("rptr",       int'(rptr),       gray(m_rcnt));
    chk("raddr",      int'(raddr),      m_rcnt % (1 << AW));
  endtask

  // One rclk edge: advance the model with the inputs present at the edge, then compare.
  task automatic step();
    int synced;
    bit pop;
    @(posedge rclk);
    if (!rrst_n) begin
      m_rcnt = 0; m_lvl = 0; m_empty = 1; m_ae = 1; m_uf = 0;
      hist.delete();
      repeat (SS) hist.push_back(0);
    end else begin
      pop    = rinc && !m_empty;
      m_uf   = (rinc && m_empty) ? 1'b1 : (uf_clr ? 1'b0 : m_uf);
      m_rcnt = (m_rcnt + int'(pop)) % MOD;
      synced = hist.pop_front();
      hist.push_back(int'(wptr));
      m_lvl   = (ungray(synced) - m_rcnt + MOD) % MOD;
      m_empty = (m_lvl == 0);
      m_ae    = (m_lvl <= int'(ae_thresh));
    end
    #1;
    check_all();
  endtask

  initial begin
    rrst_n = 1'b0; rinc = 1'b0; uf_clr = 1'b0; wptr = '0; ae_thresh = '0;
    // 1: reset and idle
    step(); step();
    rrst_n = 1'b1;
    step();
    chk("t1_rempty", int'(rempty), 1);
    chk("t1_rlevel", int'(rlevel), 0);

    // 2: five entries, threshold 2
    ae_thresh = 5'd2; wptr = 5'(gray(5));
    repeat (3) step();
    chk("t2_lvl5", int'(rlevel), 5);
    chk("t2_ae0",  int'(raempty), 0);
    rinc = 1'b1;
    repeat (3) step();
    chk("t2_lvl2", int'(rlevel), 2);
    chk("t2_ae1",  int'(raempty), 1);
    repeat (2) step();
    rinc = 1'b0;
    chk("t2_empty", int'(rempty), 1);
    chk("t2_raddr", int'(raddr), 5);

    // 3: wrap through the top of the pointer range
    wptr = 5'(gray(14));
    repeat (3) step();
    rinc = 1'b1;
    repeat (9) step();
    rinc = 1'b0;
    chk("t3_raddr14", int'(raddr), 14);
    wptr = 5'(gray(19));
    repeat (3) step();
    chk("t3_lvl5", int'(rlevel), 5);
    rinc = 1'b1;
    repeat (5) step();
    rinc = 1'b0;
    chk("t3_rptr", int'(rptr), gray(19));
    chk("t3_raddr3", int'(raddr), 3);
    chk("t3_empty", int'(rempty), 1);

    // 4: completely full
    wptr = 5'(gray(16)); rrst_n = 1'b0;
    step();
    rrst_n = 1'b1;
    repeat (3) step();
    chk("t4_lvl16", int'(rlevel), 16);
    chk("t4_empty", int'(rempty), 0);
    chk("t4_ae",    int'(raempty), 0);

    // 5: underflow and clear priority
    wptr = '0; rrst_n = 1'b0;
    step();
    rrst_n = 1'b1;
    repeat (3) step();
    rinc = 1'b1;
    step();
    chk("t5_uf_set", int'(runderflow), 1);
    chk("t5_rbin",   int'(raddr), 0);
    rinc = 1'b0;
    step();
    chk("t5_uf_hold", int'(runderflow), 1);
    rinc = 1'b1; uf_clr = 1'b1;
    step();
    chk("t5_set_wins", int'(runderflow), 1);
    rinc = 1'b0;
    step();
    uf_clr = 1'b0;
    chk("t5_uf_clr", int'(runderflow), 0);

    // 6: reset mid-operation with a pop pending
    wptr = 5'(gray(7));
    repeat (3) step();
    chk("t6_lvl7", int'(rlevel), 7);
    rinc = 1'b1; rrst_n = 1'b0;
    step();
    chk("t6_rst_lvl",   int'(rlevel), 0);
    chk("t6_rst_empty", int'(rempty), 1);
    chk("t6_rst_rptr",  int'(rptr), 0);
    rinc = 1'b0; rrst_n = 1'b1;
    repeat (3) step();
    chk("t6_recover", int'(rlevel), 7);

    // randomized traffic; writer never exceeds the FIFO depth
    rrst_n = 1'b0; wptr = '0; w = 0;
    step();
    rrst_n = 1'b1;
    for (int n = 0; n < 600; n++) begin
      if (n % 50 == 0) ae_thresh = 5'($urandom_range(0, 16));
      if (((w - m_rcnt + MOD) % MOD) < 16 && $urandom_range(0, 2) != 0) w = (w + 1) % MOD;
      wptr   = 5'(gray(w));
      rinc   = 1'($urandom_range(0, 1));
      uf_clr = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
